// File: rtl/serial_fa_pkg.sv
// rtl/serial_fa_pkg.sv - shared types and demux reduction masks for the serial full-adder sequencer
package serial_fa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Demux outputs whose select value has odd parity (1,2,4,7) give the sum bit
  localparam logic [7:0] SUM_MASK   = 8'b1001_0110;
  // Demux outputs with two or more ones in the select (3,5,6,7) give the carry
  localparam logic [7:0] CARRY_MASK = 8'b1110_1000;

endpackage

// File: rtl/fa_demux_cell.sv
// rtl/fa_demux_cell.sv - 1-bit full adder built from a 1:8 demux reduced by sum/carry masks
module fa_demux_cell
  import serial_fa_pkg::*;
(
  input  logic       in,
  input  logic [2:0] sel,
  output logic       s,
  output logic       co
);

  logic [7:0] w_dmx;

  // Route the single data input to the demux output selected by {a, b, c}
  always_comb begin
    w_dmx      = 8'd0;
    w_dmx[sel] = in;
  end

  assign s  = |(w_dmx & SUM_MASK);
  assign co = |(w_dmx & CARRY_MASK);

endmodule

// File: rtl/serial_fa_sequencer.sv
// rtl/serial_fa_sequencer.sv - bit-serial W-bit adder controller; optional subtract mode via SERIAL_FA_SUB_EN
module serial_fa_sequencer
  import serial_fa_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef SERIAL_FA_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  state_t             r_state;
  logic [W-1:0]       r_a_sh;
  logic [W-1:0]       r_b_sh;
  logic [W-1:0]       r_sum_sh;
  logic               r_c;
  logic               r_c_msb_in;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [W-1:0]       r_sum;
  logic               r_cout;
  logic               r_ovf;
  logic               w_s;
  logic               w_co;
  logic [W-1:0]       w_b_load;
  logic               w_c_load;

  // Operand B and the initial carry as loaded on an accepted start
`ifdef SERIAL_FA_SUB_EN
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : cin;
`else
  assign w_b_load = b;
  assign w_c_load = cin;
`endif

  fa_demux_cell u_cell (
    .in  (1'b1),
    .sel ({r_a_sh[0], r_b_sh[0], r_c}),
    .s   (w_s),
    .co  (w_co)
  );

  // Control FSM: latch operands, shift one bit per cycle, publish results on DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_sum_sh   <= '0;
      r_c        <= 1'b0;
      r_c_msb_in <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_cnt  <= '0;
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= w_b_load;
            r_c     <= w_c_load;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= {w_s, r_sum_sh[W-1:1]};
          r_c      <= w_co;
          if (r_cnt == CNT_W'(W - 1)) begin
            // Carry into the MSB is the carry present before the last bit is added
            r_c_msb_in <= r_c;
            r_state    <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_sum   <= r_sum_sh;
          r_cout  <= r_c;
          r_ovf   <= r_c_msb_in ^ r_c;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_fa_sequencer.sv
// tb/tb_serial_fa_sequencer.sv - scoreboard bench for serial_fa_sequencer (subtract tests under SERIAL_FA_SUB_EN)
module tb_serial_fa_sequencer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_done   = 0;
  int   n_exp    = 0;

  serial_fa_sequencer #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_FA_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=%0h required=none", sum);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sum", 32'(sum), 32'(e.s));
          chk("cout", 32'(cout), 32'(e.c));
          chk("ovf", 32'(ovf), 32'(e.v));
        end
      end
    end
  end

  // Drive a request; returns at #1 after the accepting edge
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input logic tsub, input logic push,
                       input logic [W-1:0] es, input logic ec, input logic ev);
    exp_t e;
    a     = ta;
    b     = tb;
    cin   = tc;
    sub   = tsub;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'hA5;
    b     = 8'h5A;
    cin   = ~tc;
    if (push) begin
      e.s = es;
      e.c = ec;
      e.v = ev;
      exp_q.push_back(e);
      n_exp++;
    end
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Wait for done with a bound; k0 edges since acceptance have already elapsed
  task automatic wait_done(input int k0);
    int k;
    bit seen;
    k = k0;
    seen = 1'b0;
    while (k < 30 && !seen) begin
      @(posedge clk);
      #1;
      k++;
      if (done === 1'b1) seen = 1'b1;
    end
    chk("done_latency", 32'(k), 32'd9);
    chk("busy_in_done_cycle", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    sub   = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(8'h3C, 8'h05, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0);
    wait_done(0);
    issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    wait_done(0);
    issue(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    wait_done(0);
    issue(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
    wait_done(0);
    issue(8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    wait_done(0);

    // Start during RUN is ignored and the published result holds
    issue(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    a     = 8'h11;
    b     = 8'h11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("sum_held_in_run", 32'(sum), 32'h00);
    wait_done(3);
    // Back-to-back: request raised in the done cycle
    issue(8'h20, 8'h22, 1'b1, 1'b0, 1'b1, 8'h43, 1'b0, 1'b0);
    wait_done(0);

    // Reset during the fourth RUN cycle aborts without a done pulse
    issue(8'h55, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(8'h02, 8'h03, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0);
    wait_done(0);

`ifdef SERIAL_FA_SUB_EN
    issue(8'h10, 8'h01, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0);
    wait_done(0);
    issue(8'h00, 8'h01, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    wait_done(0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("done_pulse_count", 32'(n_done), 32'(n_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
